moravec_corner_nms: RTL and testbench

- Downstream stage of the Moravec score chain.
- Consumes the raster-ordered stream of per-pixel minimum squared-difference scores (14-bit, one per pixel) produced by the score flip-flop chain.
- Applies a run-time threshold and 3x3 non-maximum suppression, then emits one corner flag per interior pixel with its coordinates to the corner-list writer.

---
 rtl/moravec_pkg.sv | 32 +++
 rtl/moravec_line_buffer.sv | 26 ++
 rtl/moravec_corner_nms.sv | 132 +++++++++++++
 tb/tb_moravec_corner_nms.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/moravec_pkg.sv
// rtl/moravec_pkg.sv - shared types and the corner decision rule for the Moravec NMS stage
package moravec_pkg;

   localparam int SCORE_W      = 14;
   localparam int BEAT_COORD_W = 8;

   typedef logic [SCORE_W-1:0] score_t;

   localparam score_t SCORE_MAX = 14'h3FFF;

   typedef struct packed {
      logic                    corner;
      logic [BEAT_COORD_W-1:0] x;
      logic [BEAT_COORD_W-1:0] y;
      score_t                  score;
   } corner_beat_t;

   // Strict against raster-earlier neighbours, non-strict against later ones,
   // so exactly one pixel of an equal-valued plateau survives.
   function automatic logic nms_keep(input score_t       s,
                                     input score_t       thr,
                                     input score_t [3:0] earlier,
                                     input score_t [3:0] later);
      logic keep;
      keep = (s >= thr);
      for (int i = 0; i < 4; i++) begin
         keep = keep & (s > earlier[i]) & (s >= later[i]);
      end
      return keep;
   endfunction

endpackage

// File: rtl/moravec_line_buffer.sv
// rtl/moravec_line_buffer.sv - single-port circular row store, read-before-write
module moravec_line_buffer
   import moravec_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [SCORE_W-1:0] wdata,
   output logic [SCORE_W-1:0] rdata
);

   logic [SCORE_W-1:0] mem [0:DEPTH-1];

   // The read returns the previous row's value at this column before it is overwritten.
   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/moravec_corner_nms.sv
// rtl/moravec_corner_nms.sv - thresholded 3x3 non-maximum suppression over a raster score stream
module moravec_corner_nms
   import moravec_pkg::*;
#(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sof,
   input  logic               in_valid,
   input  logic [SCORE_W-1:0] in_score,
   input  logic [SCORE_W-1:0] thresh,
   output logic               out_valid,
   output logic               corner,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic [SCORE_W-1:0] out_score,
   output logic               frame_done
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;
   localparam int         LB_AW  = $clog2(IMG_W);

   logic [0:0]         state;
   logic [COORD_W-1:0] col;
   logic [COORD_W-1:0] row;
   score_t             thr;

   // Two stored columns (c-2, c-1); the live column c comes from the line buffers and the input.
   score_t             win [0:2][0:1];

   logic               accept;
   logic [COORD_W-1:0] pc;
   logic [COORD_W-1:0] pr;
   logic               last_col;
   logic               last_row;
   logic               emit;
   logic               is_corner;
   score_t             up1;
   score_t             up2;

   assign accept   = in_valid & (sof | (state == ACTIVE));
   assign pc       = sof ? '0 : col;
   assign pr       = sof ? '0 : row;
   assign last_col = (pc == COORD_W'(IMG_W - 1));
   assign last_row = (pr == COORD_W'(IMG_H - 1));
   assign emit     = accept & (pc >= COORD_W'(2)) & (pr >= COORD_W'(2));

   moravec_line_buffer #(
      .DEPTH  (IMG_W),
      .ADDR_W (LB_AW)
   ) u_lb_y1 (
      .clk   (clk),
      .we    (accept),
      .addr  (pc[LB_AW-1:0]),
      .wdata (in_score),
      .rdata (up1)
   );

   moravec_line_buffer #(
      .DEPTH  (IMG_W),
      .ADDR_W (LB_AW)
   ) u_lb_y2 (
      .clk   (clk),
      .we    (accept),
      .addr  (pc[LB_AW-1:0]),
      .wdata (up1),
      .rdata (up2)
   );

   assign is_corner = nms_keep(win[1][1], thr,
                               {win[0][0], win[0][1], up2, win[1][0]},
                               {up1, win[2][0], win[2][1], in_score});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         thr        <= '0;
         out_valid  <= 1'b0;
         corner     <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         out_score  <= '0;
         frame_done <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
               win[r][c] <= '0;
            end
         end
      end else begin
         out_valid  <= emit;
         frame_done <= emit & last_col & last_row;
         if (emit) begin
            corner    <= is_corner;
            out_x     <= pc - COORD_W'(1);
            out_y     <= pr - COORD_W'(1);
            out_score <= win[1][1];
         end
         if (accept) begin
            if (sof) begin
               thr <= thresh;
            end
            win[0][0] <= win[0][1];
            win[1][0] <= win[1][1];
            win[2][0] <= win[2][1];
            win[0][1] <= up2;
            win[1][1] <= up1;
            win[2][1] <= in_score;
            if (last_col) begin
               col <= '0;
               if (last_row) begin
                  row   <= '0;
                  state <= IDLE;
               end else begin
                  row   <= pr + COORD_W'(1);
                  state <= ACTIVE;
               end
            end else begin
               col   <= pc + COORD_W'(1);
               row   <= pr;
               state <= ACTIVE;
            end
         end
      end
   end

endmodule

// File: tb/tb_moravec_corner_nms.sv
// tb/tb_moravec_corner_nms.sv - randomized self-checking bench for moravec_corner_nms on a 5x5 frame
module tb_moravec_corner_nms;
   import moravec_pkg::*;

   localparam int W = 5;
   localparam int H = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sof = 1'b0;
   logic         in_valid = 1'b0;
   logic [13:0]  in_score = '0;
   logic [13:0]  thresh = '0;
   logic         out_valid;
   logic         corner;
   logic [7:0]   out_x;
   logic [7:0]   out_y;
   logic [13:0]  out_score;
   logic         frame_done;

   int total = 0;
   int bad = 0;
   int img [0:H-1][0:W-1];
   int thr_m;

   moravec_corner_nms #(.IMG_W(W), .IMG_H(H), .COORD_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid), .in_score(in_score),
      .thresh(thresh), .out_valid(out_valid), .corner(corner), .out_x(out_x),
      .out_y(out_y), .out_score(out_score), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic bit ref_corner(input int x, input int y);
      bit keep;
      keep = (img[y][x] >= thr_m);
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            if (dy < 0 || (dy == 0 && dx < 0)) keep &= (img[y][x] > img[y+dy][x+dx]);
            else keep &= (img[y][x] >= img[y+dy][x+dx]);
         end
      end
      return keep;
   endfunction

   task automatic fill(input int v);
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
   endtask

   task automatic play(input int npix, input int gap_mode,
                       output int strobes, output int corners, output int dones);
      int c, r, g;
      bit ev, ed;
      corner_beat_t got, exp, held;
      strobes = 0; corners = 0; dones = 0;
      for (int i = 0; i < npix; i++) begin
         c = i % W; r = i / W;
         in_valid = 1'b1; sof = (i == 0); in_score = 14'(img[r][c]);
         thresh = (i == 0) ? 14'(thr_m) : 14'($urandom);
         @(posedge clk); #1;
         ev = (c >= 2 && r >= 2);
         ed = (c == W-1 && r == H-1);
         total++;
         if (out_valid !== ev) begin
            bad++; $display("FAIL out_valid pix(%0d,%0d) got=%b exp=%b", c, r, out_valid, ev);
         end
         got = '{corner, out_x, out_y, out_score};
         if (ev) begin
            exp = '{ref_corner(c-1, r-1), 8'(c-1), 8'(r-1), 14'(img[r-1][c-1])};
            total++;
            if (got !== exp) begin
               bad++; $display("FAIL centre pix(%0d,%0d) got=%h exp=%h", c, r, got, exp);
            end
         end
         total++;
         if (frame_done !== ed) begin
            bad++; $display("FAIL frame_done pix(%0d,%0d) got=%b exp=%b", c, r, frame_done, ed);
         end
         if (out_valid) strobes++;
         if (out_valid && corner) corners++;
         if (frame_done) dones++;
         held = got;
         g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0; sof = 1'($urandom); in_score = 14'($urandom);
            @(posedge clk); #1;
            got = '{corner, out_x, out_y, out_score};
            total++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0 || got[29:0] !== held[29:0]) begin
               bad++; $display("FAIL gap_hold pix(%0d,%0d) valid=%b done=%b got=%h held=%h",
                               c, r, out_valid, frame_done, got, held);
            end
         end
      end
      in_valid = 1'b0; sof = 1'b0;
   endtask

   task automatic expect_counts(input string name, input int s, input int c, input int d,
                                input int es, input int ec, input int ed);
      total++;
      if (s !== es || c !== ec || d !== ed) begin
         bad++; $display("FAIL %s strobes=%0d corners=%0d dones=%0d exp %0d/%0d/%0d",
                         name, s, c, d, es, ec, ed);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; sof = 1'b1; in_score = 14'h123;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({out_valid, corner, frame_done} !== 3'b000 || out_x !== 8'd0 || out_y !== 8'd0 || out_score !== 14'd0) begin
         bad++; $display("FAIL reset_state v=%b c=%b d=%b x=%0d y=%0d s=%0d",
                         out_valid, corner, frame_done, out_x, out_y, out_score);
      end
      in_valid = 1'b0; sof = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_frame();
      int s, c, d;
      fill(0); thr_m = 1;
      play(W*H, 0, s, c, d);
      expect_counts("zero_frame", s, c, d, 9, 0, 1);
   endtask

   task automatic test_single_peak();
      int s, c, d;
      fill(10); img[2][2] = 500; thr_m = 100;
      play(W*H, 0, s, c, d);
      expect_counts("peak_t100", s, c, d, 9, 1, 1);
      thr_m = 600;
      play(W*H, 0, s, c, d);
      expect_counts("peak_t600", s, c, d, 9, 0, 1);
   endtask

   task automatic test_plateau();
      int s, c, d;
      fill(10); img[2][2] = 300; img[2][3] = 300; thr_m = 100;
      play(W*H, 0, s, c, d);
      expect_counts("plateau", s, c, d, 9, 1, 1);
   endtask

   task automatic test_valid_gaps();
      int s, c, d;
      fill(10); img[2][2] = 500; thr_m = 100;
      play(W*H, 1, s, c, d);
      expect_counts("valid_gaps", s, c, d, 9, 1, 1);
   endtask

   task automatic test_mid_sof();
      int s, c, d;
      fill(10); img[2][2] = 500; thr_m = 100;
      play(2*W + 3, 0, s, c, d);
      expect_counts("aborted", s, c, d, 1, 0, 0);
      play(W*H, 0, s, c, d);
      expect_counts("after_abort", s, c, d, 9, 1, 1);
   endtask

   task automatic test_mid_reset();
      int s, c, d;
      fill(10); img[2][2] = 500; thr_m = 100;
      play(3*W + 1, 0, s, c, d);
      rst_n = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 22; k++) begin
         if (k == 2) rst_n = 1'b1;
         in_score = 14'($urandom);
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL reset_quiet cycle=%0d valid=%b done=%b", k, out_valid, frame_done);
         end
      end
      in_valid = 1'b0;
      play(W*H, 0, s, c, d);
      expect_counts("after_reset", s, c, d, 9, 1, 1);
   endtask

   task automatic test_random();
      int s, c, d, ec;
      for (int f = 0; f < 20; f++) begin
         for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = $urandom_range(0, 7);
         thr_m = $urandom_range(0, 7);
         ec = 0;
         for (int y = 1; y < H-1; y++) for (int x = 1; x < W-1; x++) ec += ref_corner(x, y);
         play(W*H, 2, s, c, d);
         expect_counts("random", s, c, d, 9, ec, 1);
      end
   endtask

   initial begin
      test_reset();
      test_zero_frame();
      test_single_peak();
      test_plateau();
      test_valid_gaps();
      test_mid_sof();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
